// File: rtl/sigmacore_trace_buffer.sv
// rtl/sigmacore_trace_buffer.sv - PC-change trace capture into a FWFT FIFO drained by a debug host
module sigmacore_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [31:0]            pc_in,
    input  logic [31:0]            instr_in,
    input  logic                   trace_en,
    input  logic                   clear,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [31:0]            rd_pc,
    output logic [31:0]            rd_instr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ARMED, TRACING} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       pc_last_q, pc_last_d;
    logic              rd_valid_q, rd_valid_d;
    logic [63:0]       head_q, head_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [63:0]       mem_q [DEPTH];

    logic          full, cap, pop, push, drop;
    logic [CW-1:0] remain;

    always_comb begin
        full   = (count_q == CW'(DEPTH));
        pop    = rd_valid_q && rd_ready;
        cap    = trace_en && ((state_q == ARMED) ||
                              ((state_q == TRACING) && (pc_in != pc_last_q)));
        push   = cap && (!full || pop) && !clear;
        drop   = cap && full && !pop && !clear;
        remain = count_q - CW'(pop);

        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pc_last_d  = pc_last_q;
        rd_valid_d = rd_valid_q;
        head_d     = head_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            rd_valid_d = 1'b0;
            overflow_d = 1'b0;
            drop_d     = '0;
            state_d    = trace_en ? ARMED : IDLE;
        end else begin
            rd_ptr_d   = rd_ptr_q + AW'(pop);
            wr_ptr_d   = wr_ptr_q + AW'(push);
            count_d    = remain + CW'(push);
            rd_valid_d = (count_d != '0);
            // Head is registered: bypass the new entry when it lands in an empty FIFO.
            if (push && (remain == '0)) begin
                head_d = {pc_in, instr_in};
            end else if (remain != '0) begin
                head_d = mem_q[rd_ptr_d];
            end
            if (cap) begin
                pc_last_d = pc_in;
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_q != '1) begin
                    drop_d = drop_q + DROP_W'(1);
                end
            end
            if (!trace_en) begin
                state_d = IDLE;
            end else if (state_q == IDLE) begin
                state_d = ARMED;
            end else if (state_q == ARMED) begin
                state_d = TRACING;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pc_last_q  <= '0;
            rd_valid_q <= 1'b0;
            head_q     <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pc_last_q  <= pc_last_d;
            rd_valid_q <= rd_valid_d;
            head_q     <= head_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {pc_in, instr_in};
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_pc      = head_q[63:32];
    assign rd_instr   = head_q[31:0];
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_sigmacore_trace_buffer.sv
// tb/tb_sigmacore_trace_buffer.sv - self-checking bench for sigmacore_trace_buffer
module tb_sigmacore_trace_buffer;
    localparam int DEPTH  = 16;
    localparam int DROP_W = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc_in, instr_in;
    logic        trace_en, clear, rd_ready;
    logic        rd_valid;
    logic [31:0] rd_pc, rd_instr;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_count;

    sigmacore_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk(clk), .reset_n(reset_n), .pc_in(pc_in), .instr_in(instr_in),
        .trace_en(trace_en), .clear(clear), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr), .count(count),
        .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    typedef enum {M_IDLE, M_ARMED, M_TRACING} mstate_t;
    mstate_t     m_state;
    logic [31:0] m_pc_last;
    logic [63:0] m_q[$];
    logic        m_ovf;
    int          m_drop;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          exp_count;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_state   = M_IDLE;
        m_pc_last = '0;
        m_q.delete();
        m_ovf     = 1'b0;
        m_drop    = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_valid"}, 64'(rd_valid), 64'(0));
        check({tag, "_count"}, 64'(count), 64'(0));
        check({tag, "_overflow"}, 64'(overflow), 64'(0));
        check({tag, "_drop"}, 64'(drop_count), 64'(0));
        check({tag, "_rd_pc"}, 64'(rd_pc), 64'(0));
        check({tag, "_rd_instr"}, 64'(rd_instr), 64'(0));
    endtask

    // Called at a falling edge: compare DUT vs scoreboard, drive, clock, update model.
    task automatic step(input logic [31:0] pc, input logic [31:0] ins,
                        input logic en, input logic clr, input logic rdy);
        bit          m_pop, m_cap;
        logic [63:0] popped;
        check("rd_valid", 64'(rd_valid), 64'(m_q.size() != 0));
        check("count", 64'(count), 64'(m_q.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("drop_count", 64'(drop_count), 64'(m_drop));
        if (m_q.size() != 0) check("head", {rd_pc, rd_instr}, m_q[0]);
        pc_in = pc; instr_in = ins; trace_en = en; clear = clr; rd_ready = rdy;
        @(posedge clk);
        m_pop = (m_q.size() != 0) && rdy;
        m_cap = en && ((m_state == M_ARMED) || (m_state == M_TRACING && pc != m_pc_last));
        if (clr) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_drop  = 0;
            m_state = en ? M_ARMED : M_IDLE;
        end else begin
            if (m_pop) popped = m_q.pop_front();
            if (m_cap) begin
                m_pc_last = pc;
                if (m_q.size() < DEPTH) m_q.push_back({pc, ins});
                else begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end
            if (!en) m_state = M_IDLE;
            else if (m_state == M_IDLE) m_state = M_ARMED;
            else if (m_state == M_ARMED) m_state = M_TRACING;
        end
        @(negedge clk);
    endtask

    initial begin
        int ready_pct;
        vecs[0] = '{32'h0, 32'hCAFEF2B7, 1};
        vecs[1] = '{32'h4, 32'h10028313, 2};
        vecs[2] = '{32'h8, 32'h006283B3, 3};
        vecs[3] = '{32'hC, 32'h0072A623, 4};

        reset_n = 1'b0; pc_in = '0; instr_in = '0;
        trace_en = 1'b0; clear = 1'b0; rd_ready = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Four PCs held 20 cycles each: exactly one entry per PC
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 20; k++) step(vecs[v].pc, vecs[v].instr, 1'b1, 1'b0, 1'b0);
            check("t1_count", 64'(count), 64'(vecs[v].exp_count));
        end

        // Drain, then extra pops on empty
        for (int k = 0; k < 6; k++) step(32'hC, 32'h0072A623, 1'b1, 1'b0, 1'b1);
        check("t2_count", 64'(count), 64'(0));
        check("t2_valid", 64'(rd_valid), 64'(0));
        check("t2_hold_pc", 64'(rd_pc), 64'(32'hC));
        check("t2_hold_instr", 64'(rd_instr), 64'(32'h0072A623));

        // Overflow with 20 distinct PCs
        for (int i = 0; i < 20; i++) step(32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 1'b1, 1'b0, 1'b0);
        check("t3_count", 64'(count), 64'(16));
        check("t3_overflow", 64'(overflow), 64'(1));
        check("t3_drop", 64'(drop_count), 64'(4));

        // Full + simultaneous pop and capture
        step(32'h200, 32'hABCD0001, 1'b1, 1'b0, 1'b1);
        check("t4_count", 64'(count), 64'(16));
        check("t4_drop", 64'(drop_count), 64'(4));
        for (int k = 0; k < 17; k++) step(32'h200, 32'hABCD0001, 1'b1, 1'b0, 1'b1);
        check("t4_drained", 64'(count), 64'(0));
        check("t4_last_pc", 64'(rd_pc), 64'(32'h200));
        check("t4_ovf_sticky", 64'(overflow), 64'(1));

        // Re-enable re-captures a held PC; then clear
        repeat (3) step(32'h40, 32'h13, 1'b1, 1'b0, 1'b0);
        repeat (3) step(32'h40, 32'h13, 1'b0, 1'b0, 1'b0);
        repeat (3) step(32'h40, 32'h13, 1'b1, 1'b0, 1'b0);
        check("t5_recapture", 64'(count), 64'(2));
        step(32'h44, 32'h93, 1'b1, 1'b0, 1'b0);
        check("t5_three", 64'(count), 64'(3));
        step(32'h44, 32'h93, 1'b1, 1'b1, 1'b0);
        check("t5_clr_count", 64'(count), 64'(0));
        check("t5_clr_ovf", 64'(overflow), 64'(0));
        check("t5_clr_valid", 64'(rd_valid), 64'(0));
        check("t5_clr_drop", 64'(drop_count), 64'(0));

        // Asynchronous reset in the middle of capture
        for (int i = 0; i < 5; i++) step(32'h300 + 32'(4 * i), 32'h77 + 32'(i), 1'b1, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Random stream against the scoreboard
        ready_pct = 50;
        for (int c = 0; c < 10000; c++) begin
            if (c % 1000 == 0) ready_pct = (c / 1000) % 3 == 0 ? 10 : ((c / 1000) % 3 == 1 ? 90 : 50);
            step(32'($urandom_range(0, 7)) << 2, $urandom,
                 1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 299) == 0),
                 1'($urandom_range(0, 99) < ready_pct));
        end
        step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
